// File: rtl/sh4a_regfile_wb_arbiter_if.sv
// Writeback arbiter bundle: ALU/load write requests, scoreboard
// set, hazard queries and the register file write port.
interface sh4a_regfile_wb_arbiter_if;
  logic        alu_wr_valid;
  logic [4:0]  alu_wr_idx;
  logic [31:0] alu_wr_data;
  logic        alu_wr_ready;

  logic        mem_wr_valid;
  logic [4:0]  mem_wr_idx;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;

  logic        sb_set;
  logic [4:0]  sb_set_idx;

  logic [4:0]  query0_idx;
  logic [4:0]  query1_idx;
  logic        hazard0;
  logic        hazard1;

  logic [4:0]  idx_write;
  logic [31:0] reg_write;
  logic        reg_write_enable;
  logic        err_bad_idx;

  modport master (
    output alu_wr_valid, alu_wr_idx, alu_wr_data,
    input  alu_wr_ready,
    output mem_wr_valid, mem_wr_idx, mem_wr_data,
    input  mem_wr_ready,
    output sb_set, sb_set_idx,
    output query0_idx, query1_idx,
    input  hazard0, hazard1,
    input  idx_write, reg_write, reg_write_enable,
    input  err_bad_idx
  );

  modport slave (
    input  alu_wr_valid, alu_wr_idx, alu_wr_data,
    output alu_wr_ready,
    input  mem_wr_valid, mem_wr_idx, mem_wr_data,
    output mem_wr_ready,
    input  sb_set, sb_set_idx,
    input  query0_idx, query1_idx,
    output hazard0, hazard1,
    output idx_write, reg_write, reg_write_enable,
    output err_bad_idx
  );
endinterface

// File: rtl/sh4a_regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load
// writeback; tracks outstanding loads for issue-stage hazards.
module sh4a_regfile_wb_arbiter #(
  parameter int NUM_REGS = 24,
  parameter int MAX_WAIT = 3
) (
  input logic clk,
  input logic reset,
  sh4a_regfile_wb_arbiter_if.slave wb
);

  localparam logic [5:0] NREG = 6'(NUM_REGS);
  localparam logic [2:0] WMAX = 3'(MAX_WAIT);

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic [2:0]          wait_cnt;
  logic [2:0]          wait_nxt;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                force_alu;
  logic                alu_hs;
  logic                mem_hs;
  logic                any_hs;
  wr_t                 win;
  logic                win_bad;
  logic                win_ok;
  logic [4:0]          idx_q;
  logic [31:0]         data_q;
  logic                we_q;
  logic                err_q;

  // Loads win by default; a starved ALU request wins once.
  assign force_alu = (wait_cnt == WMAX);
  assign wb.alu_wr_ready = !wb.mem_wr_valid || force_alu;
  assign wb.mem_wr_ready = !(wb.alu_wr_valid && force_alu);

  assign alu_hs = wb.alu_wr_valid && wb.alu_wr_ready;
  assign mem_hs = wb.mem_wr_valid && wb.mem_wr_ready;
  assign any_hs = alu_hs || mem_hs;

  always_comb begin
    win = '0;
    unique case (1'b1)
      alu_hs: begin
        win.idx  = wb.alu_wr_idx;
        win.data = wb.alu_wr_data;
      end
      mem_hs: begin
        win.idx  = wb.mem_wr_idx;
        win.data = wb.mem_wr_data;
      end
      default: ;
    endcase
  end

  assign win_bad = ({1'b0, win.idx} >= NREG);
  assign win_ok  = (win.idx != 5'd0) && !win_bad;

  always_comb begin
    wait_nxt = 3'd0;
    if (wb.alu_wr_valid && !alu_hs) begin
      if (wait_cnt == 3'd7)
        wait_nxt = wait_cnt;
      else
        wait_nxt = wait_cnt + 3'd1;
    end
  end

  // Set is applied after clear so it wins on a collision.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (mem_hs && wb.mem_wr_idx == 5'(i))
        pending_nxt[i] = 1'b0;
      if (wb.sb_set && i != 0 && wb.sb_set_idx == 5'(i))
        pending_nxt[i] = 1'b1;
    end
  end

  function automatic logic haz(
    input logic [4:0]          q,
    input logic [NUM_REGS-1:0] pend,
    input logic                we,
    input logic [4:0]          widx
  );
    logic h;
    h = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (q == 5'(i))
        h = pend[i] || (we && widx == q);
    end
    return h;
  endfunction

  assign wb.hazard0 = haz(wb.query0_idx, pending, we_q, idx_q);
  assign wb.hazard1 = haz(wb.query1_idx, pending, we_q, idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 3'd0;
      pending  <= '0;
      idx_q    <= 5'd0;
      data_q   <= 32'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      pending  <= pending_nxt;
      we_q     <= any_hs && win_ok;
      if (any_hs) begin
        idx_q  <= win.idx;
        data_q <= win.data;
      end
      if (any_hs && win_bad)
        err_q <= 1'b1;
    end
  end

  assign wb.idx_write        = idx_q;
  assign wb.reg_write        = data_q;
  assign wb.reg_write_enable = we_q;
  assign wb.err_bad_idx      = err_q;

endmodule

// File: tb/tb_sh4a_regfile_wb_arbiter.sv
// Bench for sh4a_regfile_wb_arbiter: vector table, corner
// sequences and a random run against a reference model.
module tb_sh4a_regfile_wb_arbiter;
  localparam int NR = 24;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sh4a_regfile_wb_arbiter_if bus();

  sh4a_regfile_wb_arbiter #(
    .NUM_REGS(NR),
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic av; logic [4:0] ai; logic [31:0] ad;
    logic mv; logic [4:0] mi; logic [31:0] md;
    logic sv; logic [4:0] si;
    logic [4:0] q0; logic [4:0] q1;
    logic ar; logic mr; logic h0; logic h1;
    logic we; logic [4:0] wi; logic [31:0] wd; logic err;
  } vec_t;

  function automatic vec_t mk(
    logic av, logic [4:0] ai, logic [31:0] ad,
    logic mv, logic [4:0] mi, logic [31:0] md,
    logic sv, logic [4:0] si, logic [4:0] q0, logic [4:0] q1,
    logic ar, logic mr, logic h0, logic h1,
    logic we, logic [4:0] wi, logic [31:0] wd, logic err);
    vec_t v;
    v.av = av; v.ai = ai; v.ad = ad;
    v.mv = mv; v.mi = mi; v.md = md;
    v.sv = sv; v.si = si; v.q0 = q0; v.q1 = q1;
    v.ar = ar; v.mr = mr; v.h0 = h0; v.h1 = h1;
    v.we = we; v.wi = wi; v.wd = wd; v.err = err;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ai,
                       input logic [31:0] ad, input logic mv,
                       input logic [4:0] mi, input logic [31:0] md,
                       input logic sv, input logic [4:0] si,
                       input logic [4:0] q0, input logic [4:0] q1);
    bus.alu_wr_valid = av; bus.alu_wr_idx = ai; bus.alu_wr_data = ad;
    bus.mem_wr_valid = mv; bus.mem_wr_idx = mi; bus.mem_wr_data = md;
    bus.sb_set = sv; bus.sb_set_idx = si;
    bus.query0_idx = q0; bus.query1_idx = q1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t vt[11];

  // Reference model state
  bit [31:0] mpend;
  int        mstarve;
  bit        mwe;
  bit        merr;
  bit [4:0]  midx;
  bit [31:0] mdata;

  function automatic bit exp_haz(bit [4:0] q);
    if (q == 0 || int'(q) >= NR) return 1'b0;
    return mpend[q] || (mwe && midx == q);
  endfunction

  logic        av, mv, sv;
  logic [4:0]  ai, mi, si, q0, q1;
  logic [31:0] ad, md;
  bit          alu_hold, mem_hold;
  int          w;
  logic [4:0]  wi;
  logic [31:0] wd;

  initial begin
    reset = 1'b1;
    idle();
    #12;
    chk("reset we", bus.reg_write_enable, 0);
    chk("reset idx", bus.idx_write, 0);
    chk("reset data", bus.reg_write, 0);
    chk("reset err", bus.err_bad_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    vt[0]  = mk(1, 2, 32'hA, 0, 0, 0, 1, 6, 2, 6,
                1, 1, 0, 0, 1, 2, 32'hA, 0);
    vt[1]  = mk(0, 0, 0, 1, 6, 32'hB, 0, 0, 2, 6,
                1, 1, 1, 1, 1, 6, 32'hB, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 2,
                1, 1, 1, 0, 0, 6, 32'hB, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0,
                1, 1, 0, 0, 0, 6, 32'hB, 0);
    vt[4]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 6,
                1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    vt[5]  = mk(0, 0, 0, 1, 30, 32'h5, 0, 0, 0, 0,
                1, 1, 0, 0, 0, 30, 32'h5, 1);
    vt[6]  = mk(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0,
                0, 1, 0, 0, 1, 4, 32'h22, 1);
    vt[7]  = mk(1, 3, 32'h11, 1, 8, 32'h33, 0, 0, 4, 3,
                0, 1, 1, 0, 1, 8, 32'h33, 1);
    vt[8]  = mk(1, 3, 32'h11, 1, 9, 32'h44, 0, 0, 8, 9,
                0, 1, 1, 0, 1, 9, 32'h44, 1);
    vt[9]  = mk(1, 3, 32'h11, 1, 10, 32'h55, 0, 0, 9, 10,
                1, 0, 1, 0, 1, 3, 32'h11, 1);
    vt[10] = mk(0, 0, 0, 1, 10, 32'h55, 0, 0, 3, 0,
                1, 1, 1, 0, 1, 10, 32'h55, 1);

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].av, vt[i].ai, vt[i].ad, vt[i].mv, vt[i].mi,
            vt[i].md, vt[i].sv, vt[i].si, vt[i].q0, vt[i].q1);
      @(negedge clk);
      if (vt[i].av)
        chk($sformatf("v%0d alu_rdy", i), bus.alu_wr_ready, vt[i].ar);
      if (vt[i].mv)
        chk($sformatf("v%0d mem_rdy", i), bus.mem_wr_ready, vt[i].mr);
      chk($sformatf("v%0d haz0", i), bus.hazard0, vt[i].h0);
      chk($sformatf("v%0d haz1", i), bus.hazard1, vt[i].h1);
      @(posedge clk); #1;
      chk($sformatf("v%0d we", i), bus.reg_write_enable, vt[i].we);
      chk($sformatf("v%0d idx", i), bus.idx_write, vt[i].wi);
      chk($sformatf("v%0d data", i), bus.reg_write, vt[i].wd);
      chk($sformatf("v%0d err", i), bus.err_bad_idx, vt[i].err);
    end

    // Reset lands mid-cycle after an ALU grant to r5
    idle();
    drive(1, 5, 32'h55AA, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst alu_rdy", bus.alu_wr_ready, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst async we", bus.reg_write_enable, 0);
    chk("rst async idx", bus.idx_write, 0);
    chk("rst async data", bus.reg_write, 0);
    chk("rst async err", bus.err_bad_idx, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst no r5 write", bus.reg_write_enable, 0);
    end
    for (int q = 1; q < NR; q++) begin
      bus.query0_idx = 5'(q);
      #1;
      chk($sformatf("rst pend q%0d", q), bus.hazard0, 0);
    end
    @(posedge clk); #1;

    // Load hazard on r7
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    @(negedge clk);
    chk("lh set cycle", bus.hazard0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    chk("lh pending", bus.hazard0, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, 7, 0);
    @(negedge clk);
    chk("lh mem_rdy", bus.mem_wr_ready, 1);
    chk("lh hs cycle", bus.hazard0, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("lh we", bus.reg_write_enable, 1);
    chk("lh idx", bus.idx_write, 7);
    chk("lh data", bus.reg_write, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lh commit cycle", bus.hazard0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lh cleared", bus.hazard0, 0);
    @(posedge clk); #1;

    // Set and clear of r9 in one cycle
    drive(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
    @(negedge clk);
    chk("sc mem_rdy", bus.mem_wr_ready, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("sc we", bus.reg_write_enable, 1);
    chk("sc idx", bus.idx_write, 9);
    chk("sc data", bus.reg_write, 32'h99);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sc pending kept", bus.hazard0, 1);
    @(posedge clk); #1;

    // Random run against the reference model
    idle();
    reset = 1'b1;
    #2;
    mpend = '0; mstarve = 0; mwe = 0; merr = 0;
    midx = '0; mdata = '0;
    alu_hold = 0; mem_hold = 0;
    av = 0; ai = 0; ad = 0; mv = 0; mi = 0; md = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int c = 0; c < 3000; c++) begin
      if (!alu_hold) begin
        av = ($urandom_range(1, 0) == 1);
        ai = 5'($urandom_range(31, 0));
        ad = $urandom;
      end
      if (!mem_hold) begin
        mv = ($urandom_range(9, 0) < 7);
        mi = 5'($urandom_range(31, 0));
        md = $urandom;
      end
      sv = ($urandom_range(3, 0) == 0);
      si = 5'($urandom_range(31, 0));
      q0 = 5'($urandom_range(25, 0));
      q1 = 5'($urandom_range(25, 0));
      drive(av, ai, ad, mv, mi, md, sv, si, q0, q1);
      @(negedge clk);

      if (av && mv) w = (mstarve >= MW) ? 1 : 2;
      else if (av)  w = 1;
      else if (mv)  w = 2;
      else          w = 0;

      if (av) chk("rnd alu_rdy", bus.alu_wr_ready, w == 1);
      if (mv) chk("rnd mem_rdy", bus.mem_wr_ready, w == 2);
      chk("rnd haz0", bus.hazard0, exp_haz(q0));
      chk("rnd haz1", bus.hazard1, exp_haz(q1));
      chk("rnd we", bus.reg_write_enable, mwe);
      chk("rnd idx", bus.idx_write, midx);
      chk("rnd data", bus.reg_write, mdata);
      chk("rnd err", bus.err_bad_idx, merr);

      if (w != 0) begin
        wi = (w == 1) ? ai : mi;
        wd = (w == 1) ? ad : md;
        mwe = (wi != 0) && (int'(wi) < NR);
        if (int'(wi) >= NR) merr = 1'b1;
        midx = wi;
        mdata = wd;
      end else begin
        mwe = 1'b0;
      end
      mstarve = (av && w != 1) ? mstarve + 1 : 0;
      if (w == 2) mpend[mi] = 1'b0;
      if (sv && si != 0 && int'(si) < NR) mpend[si] = 1'b1;
      alu_hold = av && (w != 1);
      mem_hold = mv && (w != 2);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sh4a_regfile_wb_arbiter.md
# sh4a_regfile_wb_arbiter

Shares the register file's single write port between the ALU writeback path and the memory-load writeback path, and keeps a load scoreboard for the issue stage. It sits between the execute/memory stages and the register file. It drives the register file's `idx_write`, `reg_write` and `reg_write_enable` from a registered output stage. It also flags read-after-write hazards on the two register file read indices.

## Interface
- `NUM_REGS`, 24, number of architecturally valid register indices (0..NUM_REGS-1); index 0 is REG_ZERO.
- `MAX_WAIT`, 3, consecutive cycles an ALU request may lose arbitration before it is force-granted (1..7).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_wr_valid`  in  1  ALU writeback request.
- `alu_wr_idx`  in  5  ALU destination index.
- `alu_wr_data`  in  32  ALU result.
- `alu_wr_ready`  out  1  ALU request accepted this cycle (combinational).
- `mem_wr_valid`  in  1  load writeback request.
- `mem_wr_idx`  in  5  load destination index.
- `mem_wr_data`  in  32  load data.
- `mem_wr_ready`  out  1  load request accepted this cycle (combinational).
- `sb_set`  in  1  load issued; mark `sb_set_idx` pending.
- `sb_set_idx`  in  5  destination of the issued load.
- `query0_idx`, `query1_idx`  in  5 each  read indices about to go to the register file.
- `hazard0`, `hazard1`  out  1 each  the matching query index is not yet safe to read (combinational).
- `idx_write`  out  5  register file write index (registered).
- `reg_write`  out  32  register file write data (registered).
- `reg_write_enable`  out  1  register file write strobe (registered).
- `err_bad_idx`  out  1  sticky flag: a write with index >= NUM_REGS was accepted.

## Operation
- **Arbitration.** At most one grant per cycle. A handshake occurs when valid && ready.
  - Default priority: the mem request wins over the ALU request.
  - `wait_cnt` (3 bits) counts consecutive cycles in which `alu_wr_valid`=1 and the ALU is not granted. It is cleared on an ALU grant, or when `alu_wr_valid`=0.
  - When `wait_cnt` == MAX_WAIT, the ALU wins over mem for that cycle.
  - A single valid requester is always granted.
  - Requesters must hold valid, idx and data stable until ready.
- **Output stage.** On a granted handshake, the next edge loads `idx_write`/`reg_write` from the winner.
  - `reg_write_enable` <= 1 only if idx != 0 and idx < NUM_REGS.
  - With no grant, `reg_write_enable` <= 0 and idx/data hold their previous values.
- **Index filtering.**
  - A write to index 0 is accepted and silently dropped.
  - A write to index >= NUM_REGS is accepted and dropped, and sets `err_bad_idx`. The flag stays set until reset.
- **Scoreboard.** `pending[NUM_REGS-1:0]`.
  - `sb_set` with idx in 1..NUM_REGS-1 sets `pending[idx]`. `sb_set` with idx 0 or an out-of-range idx is ignored.
  - A mem handshake clears `pending[mem_wr_idx]`.
  - If set and clear hit the same index in the same cycle, set wins.
  - ALU writes never touch `pending`.
- **Hazards.** `hazardN` = (queryN_idx != 0) && (`pending[queryN_idx]` || (`reg_write_enable` && `idx_write` == queryN_idx)).
  - The second term covers the commit cycle, because register file reads are registered.
  - A query index >= NUM_REGS gives hazard 0.

## Timing
- **Reset (async, immediate).** These outputs and state go to 0: `idx_write`, `reg_write`, `reg_write_enable`, `pending`, `wait_cnt`, `err_bad_idx`.
  - The ready and hazard outputs follow their combinational equations on the reset state.
  - Reset mid-handshake drops the write: it is never committed.
- **Latency.** A handshake in cycle N puts `reg_write_enable`=1 during cycle N+1, and the register file stores the value at the end of N+1.
- **Throughput.** One write per cycle, sustained.
- **Back-to-back writes.** Consecutive grants to the same index commit in grant order.
- **Scoreboard update.** An update made in cycle N is visible on the hazard outputs in cycle N+1. A clear of `pending` in N is covered during N+1 by the commit term.

## Test plan
- **Reset state.** Assert `reset` mid-cycle, with `alu_wr_valid`=1 and idx=5 already granted -> outputs go 0 immediately, no write to r5 at any later point, `pending`=0.
- **Simultaneous requests.** ALU (idx 3, 0x11) and mem (idx 4, 0x22) both valid, held continuously -> mem granted first. Then the ALU is starved until `wait_cnt`=3 forces an ALU grant: r3=0x11 commits exactly 3 cycles after the mem commit, and no write is lost.
- **Load hazard.** `sb_set` idx 7, then `query0_idx`=7 -> `hazard0`=1 from the next cycle. A mem handshake on idx 7 with 0xDEADBEEF -> `hazard0` stays 1 through the commit cycle and drops to 0 the cycle after.
- **Set/clear same cycle.** `sb_set` idx 9 together with a mem handshake to idx 9 -> `pending[9]` stays 1 and the write still commits.
- **Zero register.** ALU write idx 0, data 0xFFFFFFFF -> `alu_wr_ready`=1, `reg_write_enable` stays 0, `hazard0` with query 0 stays 0.
- **Out-of-range index.** Mem write idx 30 -> accepted, no strobe, `err_bad_idx`=1 and held until reset.
